// File: rtl/packetgen_pkg.sv
// Shared definitions for the packet generator / checker pair: error bit
// positions, Ethernet header geometry and header field extraction helpers.
package packetgen_pkg;

  localparam int ERR_FLOW    = 0;
  localparam int ERR_KEEP    = 1;
  localparam int ERR_LEN     = 2;
  localparam int ERR_HDR     = 3;
  localparam int ERR_PAYLOAD = 4;
  localparam int ERR_W       = 5;

  localparam int ETH_HDR_BYTES = 14;
  localparam int DMAC_OFF      = 0;
  localparam int SMAC_OFF      = 6;
  localparam int ETYPE_OFF     = 12;

  typedef enum logic {ST_IDLE = 1'b0, ST_BODY = 1'b1} chk_state_e;

  // Network byte order: the byte at the lowest offset is the MSB.
  function automatic logic [47:0] get_mac(input logic [127:0] lo, input int off);
    logic [47:0] m;
    m = '0;
    for (int i = 0; i < 6; i++) m = {m[39:0], lo[8*(off+i) +: 8]};
    return m;
  endfunction

  function automatic logic [15:0] get_u16(input logic [127:0] lo, input int off);
    return {lo[8*off +: 8], lo[8*(off+1) +: 8]};
  endfunction

endpackage

// File: rtl/packet_flow_match.sv
// Destination MAC -> flow index lookup. Lowest matching index wins;
// idx is 0 when nothing matches.
module packet_flow_match #(
  parameter int                    N_FLOWS = 4,
  parameter logic [48*N_FLOWS-1:0] D_MACS  = '0,
  parameter int                    FW      = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
  input  logic [47:0]   d_mac,
  output logic          hit,
  output logic [FW-1:0] idx
);

  // Scan from the top down so the lowest matching flow overrides.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_FLOWS - 1; i >= 0; i--) begin
      if (d_mac == D_MACS[48*i +: 48]) begin
        hit = 1'b1;
        idx = FW'(i);
      end
    end
  end

endmodule

// File: rtl/packet_checker.sv
// RX frame checker: classifies AXI-Stream Ethernet frames by destination
// MAC, checks header/fill/length/keep, reports one result per frame and
// keeps per-flow statistics.
module packet_checker
  import packetgen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 512,
  parameter int                    N_FLOWS    = 4,
  parameter logic [11*N_FLOWS-1:0] SIZES      = {N_FLOWS{11'd192}},
  parameter logic [48*N_FLOWS-1:0] D_MACS     = {48'hABCDEF000004, 48'hABCDEF000003,
                                                 48'hABCDEF000002, 48'hABCDEF000001},
  parameter logic [48*N_FLOWS-1:0] S_MACS     = {48'hBEEFBEEF0004, 48'hBEEFBEEF0003,
                                                 48'hBEEFBEEF0002, 48'hBEEFBEEF0001},
  parameter logic [16*N_FLOWS-1:0] ETHERTYPES = {N_FLOWS{16'h0800}},
  parameter logic [8*N_FLOWS-1:0]  PAYLOADS   = {8'hDD, 8'hCC, 8'hBB, 8'hAA},
  localparam int                   KW         = DATA_WIDTH / 8,
  localparam int                   FW         = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [KW-1:0]           s_axis_tkeep,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    stat_clear,
  output logic                    pkt_done,
  output logic [FW-1:0]           pkt_flow,
  output logic [ERR_W-1:0]        pkt_err,
  output logic [32*N_FLOWS-1:0]   flow_pkt_count,
  output logic [32*N_FLOWS-1:0]   flow_err_count,
  output logic [48*N_FLOWS-1:0]   flow_byte_count,
  output logic [31:0]             unknown_count
);

  localparam int CW = $clog2(KW + 1);

  chk_state_e                  state;
  logic                        ready;
  logic [FW-1:0]               cur_flow;
  logic                        cur_hit, keep_acc, pay_acc, hdr_acc;
  logic [15:0]                 byte_cnt, pkt_len;
  logic [N_FLOWS-1:0][31:0]    pkt_cnt, err_cnt;
  logic [N_FLOWS-1:0][47:0]    byte_sum;
  logic [31:0]                 unk_cnt;

  logic                        accept, beat0, m_hit;
  logic [FW-1:0]               m_idx;
  logic [47:0]                 d_mac, s_mac;
  logic [15:0]                 etype;

  assign accept = s_axis_tvalid && ready;
  assign beat0  = (state == ST_IDLE);
  assign d_mac  = get_mac(s_axis_tdata[127:0], DMAC_OFF);
  assign s_mac  = get_mac(s_axis_tdata[127:0], SMAC_OFF);
  assign etype  = get_u16(s_axis_tdata[127:0], ETYPE_OFF);

  packet_flow_match #(.N_FLOWS(N_FLOWS), .D_MACS(D_MACS), .FW(FW)) u_match (
    .d_mac (d_mac),
    .hit   (m_hit),
    .idx   (m_idx)
  );

  logic                 hit_n, keep_n, pay_n, hdr_n, short_n;
  logic [FW-1:0]        flow_n;
  logic [7:0]           fill;
  logic [CW-1:0]        ones;
  logic [15:0]          base, cnt_n;
  logic [16:0]          sum;
  logic [ERR_W-1:0]     err_n;

  // Fold the current beat into the running frame state; err_n is the
  // verdict if this beat turns out to be the last one.
  always_comb begin
    hit_n  = beat0 ? m_hit : cur_hit;
    flow_n = beat0 ? m_idx : cur_flow;
    fill   = PAYLOADS[8*flow_n +: 8];
    ones   = '0;
    pay_n  = beat0 ? 1'b0 : pay_acc;
    for (int k = 0; k < KW; k++) begin
      ones = ones + CW'(s_axis_tkeep[k]);
      if (s_axis_tkeep[k] && (!beat0 || k >= ETH_HDR_BYTES) &&
          s_axis_tdata[8*k +: 8] != fill)
        pay_n = 1'b1;
    end
    base    = beat0 ? 16'd0 : byte_cnt;
    sum     = {1'b0, base} + 17'(ones);
    cnt_n   = sum[16] ? 16'hFFFF : sum[15:0];
    // Last beat may be partial but must be a run of ones from bit 0.
    keep_n  = (beat0 ? 1'b0 : keep_acc) |
              (s_axis_tlast ? |(s_axis_tkeep & (s_axis_tkeep + KW'(1))) : ~&s_axis_tkeep);
    hdr_n   = beat0 ? (s_mac != S_MACS[48*m_idx +: 48] ||
                       etype != ETHERTYPES[16*m_idx +: 16]) : hdr_acc;
    short_n = cnt_n < 16'(ETH_HDR_BYTES);
    err_n              = '0;
    err_n[ERR_FLOW]    = !hit_n;
    err_n[ERR_KEEP]    = keep_n;
    // Without a flow match there is no expected size; only runts are LEN.
    err_n[ERR_LEN]     = short_n || (hit_n && cnt_n != 16'(SIZES[11*flow_n +: 11]));
    err_n[ERR_HDR]     = hit_n && !short_n && hdr_n;
    err_n[ERR_PAYLOAD] = hit_n && pay_n;
  end

  // IDLE/BODY frame tracker with registered per-frame result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ready    <= 1'b0;
      cur_flow <= '0;
      cur_hit  <= 1'b0;
      keep_acc <= 1'b0;
      pay_acc  <= 1'b0;
      hdr_acc  <= 1'b0;
      byte_cnt <= '0;
      pkt_done <= 1'b0;
      pkt_flow <= '0;
      pkt_err  <= '0;
      pkt_len  <= '0;
    end else begin
      ready    <= 1'b1;
      pkt_done <= 1'b0;
      if (accept) begin
        cur_flow <= flow_n;
        cur_hit  <= hit_n;
        keep_acc <= keep_n;
        pay_acc  <= pay_n;
        hdr_acc  <= hdr_n;
        byte_cnt <= cnt_n;
        if (s_axis_tlast) begin
          state    <= ST_IDLE;
          pkt_done <= 1'b1;
          pkt_flow <= flow_n;
          pkt_err  <= err_n;
          pkt_len  <= cnt_n;
        end else begin
          state <= ST_BODY;
        end
      end
    end
  end

  // Statistics update in the pkt_done cycle; a clear always wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt  <= '0;
      err_cnt  <= '0;
      byte_sum <= '0;
      unk_cnt  <= '0;
    end else if (stat_clear) begin
      pkt_cnt  <= '0;
      err_cnt  <= '0;
      byte_sum <= '0;
      unk_cnt  <= '0;
    end else if (pkt_done) begin
      if (pkt_err == '0) begin
        pkt_cnt[pkt_flow]  <= pkt_cnt[pkt_flow] + 32'd1;
        byte_sum[pkt_flow] <= byte_sum[pkt_flow] + 48'(pkt_len);
      end else if (pkt_err[ERR_FLOW]) begin
        unk_cnt <= unk_cnt + 32'd1;
      end else begin
        err_cnt[pkt_flow] <= err_cnt[pkt_flow] + 32'd1;
      end
    end
  end

  assign s_axis_tready   = ready;
  assign flow_pkt_count  = pkt_cnt;
  assign flow_err_count  = err_cnt;
  assign flow_byte_count = byte_sum;
  assign unknown_count   = unk_cnt;

endmodule
